// File: rtl/hack_pkg.sv
// Shared types, instruction field positions and the jump predicate for the
// multi-cycle Hack CPU.
package hack_pkg;

  localparam int WORD_W = 16;
  localparam int ADDR_W = 15;

  localparam int CI_BIT   = 15;
  localparam int A_BIT    = 12;
  localparam int COMP_MSB = 11;
  localparam int COMP_LSB = 6;
  localparam int DEST_A   = 5;
  localparam int DEST_D   = 4;
  localparam int DEST_M   = 3;
  localparam int JMP_LT   = 2;
  localparam int JMP_EQ   = 1;
  localparam int JMP_GT   = 0;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    DECODE = 2'd1,
    EXEC   = 2'd2
  } state_t;

  function automatic logic jumpTaken(input logic [2:0] jmp, input logic zr, input logic ng);
    return (jmp[JMP_LT] & ng) | (jmp[JMP_EQ] & zr) | (jmp[JMP_GT] & ~ng & ~zr);
  endfunction

endpackage

// File: rtl/hack_cpu_mc_alu.sv
// Combinational Hack ALU: optional zero/negate on each operand, add or AND,
// optional output negate, plus zero and negative flags.
module hack_cpu_mc_alu
  import hack_pkg::*;
(
  input  logic [WORD_W-1:0] x,
  input  logic [WORD_W-1:0] y,
  input  logic              zx,
  input  logic              nx,
  input  logic              zy,
  input  logic              ny,
  input  logic              f,
  input  logic              no,
  output logic [WORD_W-1:0] out,
  output logic              zr,
  output logic              ng
);

  logic [WORD_W-1:0] xZero_s;
  logic [WORD_W-1:0] xNeg_s;
  logic [WORD_W-1:0] yZero_s;
  logic [WORD_W-1:0] yNeg_s;
  logic [WORD_W-1:0] fOut_s;

  assign xZero_s = zx ? {WORD_W{1'b0}} : x;
  assign xNeg_s  = nx ? ~xZero_s : xZero_s;
  assign yZero_s = zy ? {WORD_W{1'b0}} : y;
  assign yNeg_s  = ny ? ~yZero_s : yZero_s;
  assign fOut_s  = f ? (xNeg_s + yNeg_s) : (xNeg_s & yNeg_s);
  assign out     = no ? ~fOut_s : fOut_s;
  assign zr      = (out == {WORD_W{1'b0}});
  assign ng      = out[WORD_W-1];

endmodule

// File: rtl/hack_cpu_mc.sv
// Multi-cycle Hack CPU: FETCH/DECODE/EXEC sequencing around the combinational
// ALU, with A/D/PC writeback and single-port ROM/RAM strobes.
module hack_cpu_mc
  import hack_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  output logic              instr_rd,
  output logic [ADDR_W-1:0] instr_addr,
  input  logic [WORD_W-1:0] instr_data,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [WORD_W-1:0] mem_rdata,
  output logic [WORD_W-1:0] mem_wdata,
  output logic [ADDR_W-1:0] dbg_pc,
  output logic [WORD_W-1:0] dbg_a,
  output logic [WORD_W-1:0] dbg_d
);

  state_t            state_r;
  state_t            nextState_s;
  logic [ADDR_W-1:0] pc_r;
  logic [WORD_W-1:0] a_r;
  logic [WORD_W-1:0] d_r;
  // Bits 15:13 carry nothing once DECODE has routed the instruction.
  logic [A_BIT:0]    ir_r;
  logic [WORD_W-1:0] aluY_s;
  logic [WORD_W-1:0] aluOut_s;
  logic              aluZr_s;
  logic              aluNg_s;
  logic              jump_s;

  assign aluY_s = ir_r[A_BIT] ? mem_rdata : a_r;
  assign jump_s = jumpTaken(ir_r[JMP_LT:JMP_GT], aluZr_s, aluNg_s);

  hack_cpu_mc_alu uAlu (
    .x   (d_r),
    .y   (aluY_s),
    .zx  (ir_r[COMP_MSB]),
    .nx  (ir_r[COMP_MSB-1]),
    .zy  (ir_r[COMP_MSB-2]),
    .ny  (ir_r[COMP_MSB-3]),
    .f   (ir_r[COMP_MSB-4]),
    .no  (ir_r[COMP_LSB]),
    .out (aluOut_s),
    .zr  (aluZr_s),
    .ng  (aluNg_s)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= FETCH;
    end else begin
      state_r <= nextState_s;
    end
  end

  // Next-state decode; A-instructions retire in DECODE.
  always_comb begin
    nextState_s = FETCH;
    case (state_r)
      FETCH:   nextState_s = DECODE;
      DECODE:  nextState_s = instr_data[CI_BIT] ? EXEC : FETCH;
      EXEC:    nextState_s = FETCH;
      default: nextState_s = FETCH;
    endcase
  end

  // Strobes and RAM bus; reset forces everything to zero combinationally.
  always_comb begin
    instr_rd  = 1'b0;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = {ADDR_W{1'b0}};
    mem_wdata = {WORD_W{1'b0}};
    if (reset) begin
      instr_rd = 1'b0;
    end else begin
      mem_addr = a_r[ADDR_W-1:0];
      case (state_r)
        FETCH:   instr_rd = 1'b1;
        DECODE:  mem_rd = instr_data[CI_BIT] & instr_data[A_BIT];
        EXEC: begin
          mem_wr    = ir_r[DEST_M];
          mem_wdata = aluOut_s;
        end
        default: instr_rd = 1'b0;
      endcase
    end
  end

  // Architectural registers; EXEC updates all read the pre-update A/D/PC.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_r <= {ADDR_W{1'b0}};
      a_r  <= {WORD_W{1'b0}};
      d_r  <= {WORD_W{1'b0}};
      ir_r <= {(A_BIT+1){1'b0}};
    end else begin
      case (state_r)
        DECODE: begin
          ir_r <= instr_data[A_BIT:0];
          if (!instr_data[CI_BIT]) begin
            a_r  <= instr_data;
            pc_r <= pc_r + 15'd1;
          end
        end
        EXEC: begin
          if (ir_r[DEST_A]) a_r <= aluOut_s;
          if (ir_r[DEST_D]) d_r <= aluOut_s;
          pc_r <= jump_s ? a_r[ADDR_W-1:0] : (pc_r + 15'd1);
        end
        default: pc_r <= pc_r;
      endcase
    end
  end

  assign instr_addr = pc_r;
  assign dbg_pc     = pc_r;
  assign dbg_a      = a_r;
  assign dbg_d      = d_r;

endmodule

// File: tb/tb_hack_cpu_mc.sv
// Directed bench for hack_cpu_mc: ROM/RAM models, a scoreboard of expected
// RAM accesses, and per-instruction latency and register checks.
module tb_hack_cpu_mc;

  logic        clk;
  logic        reset;
  logic        instr_rd;
  logic [14:0] instr_addr;
  logic [15:0] instr_data;
  logic        mem_rd;
  logic        mem_wr;
  logic [14:0] mem_addr;
  logic [15:0] mem_rdata;
  logic [15:0] mem_wdata;
  logic [14:0] dbg_pc;
  logic [15:0] dbg_a;
  logic [15:0] dbg_d;

  logic [15:0] rom [0:32767];
  logic [15:0] ram [0:32767];
  logic        pokeReq;
  logic [14:0] pokeAddr;
  logic [15:0] pokeData;

  logic [30:0] expWr[$];
  logic [14:0] expRd[$];

  int testsRun;
  int testsFailed;

  hack_cpu_mc dut (
    .clk        (clk),
    .reset      (reset),
    .instr_rd   (instr_rd),
    .instr_addr (instr_addr),
    .instr_data (instr_data),
    .mem_rd     (mem_rd),
    .mem_wr     (mem_wr),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .mem_wdata  (mem_wdata),
    .dbg_pc     (dbg_pc),
    .dbg_a      (dbg_a),
    .dbg_d      (dbg_d)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // 1-cycle-latency ROM and RAM models.
  always @(posedge clk) begin
    if (instr_rd) instr_data <= rom[instr_addr];
    if (mem_rd) mem_rdata <= ram[mem_addr];
    if (mem_wr) ram[mem_addr] <= mem_wdata;
    else if (pokeReq) ram[pokeAddr] <= pokeData;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testsRun++;
    assert (obs === exp) else begin
      testsFailed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // RAM-access scoreboard, sampled on the falling edge.
  always @(negedge clk) begin
    logic [30:0] e;
    if (mem_rd || mem_wr) check("rd/wr exclusive", {31'd0, mem_rd & mem_wr}, 32'd0);
    if (mem_wr) begin
      if (expWr.size() == 0) check("mem_wr expected", {31'd0, mem_wr}, 32'd0);
      else begin
        e = expWr.pop_front();
        check("mem_wr addr/data", {1'b0, mem_addr, mem_wdata}, {1'b0, e});
      end
    end
    if (mem_rd) begin
      if (expRd.size() == 0) check("mem_rd expected", {31'd0, mem_rd}, 32'd0);
      else check("mem_rd addr", {17'd0, mem_addr}, {17'd0, expRd.pop_front()});
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
    pokeReq = 1'b0;
  endtask

  task automatic poke(input logic [14:0] addr, input logic [15:0] data);
    pokeAddr = addr;
    pokeData = data;
    pokeReq  = 1'b1;
  endtask

  task automatic runInstr(input string tag, input int expCycles);
    int n;
    n = 0;
    step();
    n++;
    while (!instr_rd && n < 10) begin
      step();
      n++;
    end
    check({tag, " latency"}, n, expCycles);
  endtask

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    reset       = 1'b1;
    pokeReq     = 1'b0;
    pokeAddr    = 15'd0;
    pokeData    = 16'd0;
    for (int i = 0; i < 32768; i++) rom[i] = 16'h0000;
    rom[0]  = 16'h0005;  rom[1]  = 16'hEC10;
    rom[2]  = 16'h0064;  rom[3]  = 16'hE7C8;
    rom[4]  = 16'h0064;  rom[5]  = 16'hFC10;
    rom[6]  = 16'hFCA8;  rom[7]  = 16'hEA90;
    rom[8]  = 16'h0014;  rom[9]  = 16'hE302;
    rom[20] = 16'hEFD0;  rom[21] = 16'h0014;
    rom[22] = 16'hE302;  rom[23] = 16'h7FFF;
    rom[24] = 16'hEA87;  rom[32767] = 16'h0003;

    step();
    step();
    check("reset strobes", {29'd0, instr_rd, mem_rd, mem_wr}, 32'd0);
    check("reset mem bus", {1'b0, mem_addr, mem_wdata}, 32'd0);
    check("reset pc", {17'd0, dbg_pc}, 32'd0);
    check("reset A/D", {dbg_a, dbg_d}, 32'd0);

    reset = 1'b0;
    #1;
    check("first fetch", {16'd0, instr_rd, instr_addr}, {16'd0, 1'b1, 15'd0});
    runInstr("@5", 2);
    check("@5 A", {16'd0, dbg_a}, 32'd5);
    check("@5 next addr", {17'd0, instr_addr}, 32'd1);
    runInstr("D=A", 3);
    check("D=A D", {16'd0, dbg_d}, 32'd5);

    runInstr("@100", 2);
    expWr.push_back({15'd100, 16'd6});
    runInstr("M=D+1", 3);
    check("M=D+1 pc", {17'd0, dbg_pc}, 32'd4);

    poke(15'd100, 16'h7FFF);
    runInstr("@100 b", 2);
    expRd.push_back(15'd100);
    runInstr("D=M", 3);
    check("D=M D", {16'd0, dbg_d}, 32'h7FFF);

    poke(15'd100, 16'd1);
    expRd.push_back(15'd100);
    expWr.push_back({15'd100, 16'd0});
    runInstr("AM=M-1", 3);
    check("AM=M-1 A", {16'd0, dbg_a}, 32'd0);
    check("AM=M-1 pc", {17'd0, dbg_pc}, 32'd7);

    runInstr("D=0", 3);
    check("D=0 D", {16'd0, dbg_d}, 32'd0);
    runInstr("@20", 2);
    runInstr("JEQ taken", 3);
    check("JEQ taken addr", {17'd0, instr_addr}, 32'd20);
    runInstr("D=1", 3);
    check("D=1 D", {16'd0, dbg_d}, 32'd1);
    runInstr("@20 b", 2);
    runInstr("JEQ not taken", 3);
    check("JEQ fallthrough addr", {17'd0, instr_addr}, 32'd23);

    runInstr("@7FFF", 2);
    runInstr("0;JMP", 3);
    check("JMP addr", {17'd0, instr_addr}, 32'h7FFF);
    rom[0] = 16'h0064;
    rom[1] = 16'hE308;
    runInstr("@3 at 7FFF", 2);
    check("pc wrap", {17'd0, instr_addr}, 32'd0);
    check("@3 A", {16'd0, dbg_a}, 32'd3);

    runInstr("@100 c", 2);
    step();
    step();
    check("M=D exec pre-reset", {15'd0, mem_wr, mem_wdata}, {15'd0, 1'b1, 16'd1});
    reset = 1'b1;
    #1;
    check("reset in EXEC strobes", {29'd0, instr_rd, mem_rd, mem_wr}, 32'd0);
    check("reset in EXEC bus", {1'b0, mem_addr, mem_wdata}, 32'd0);
    step();
    reset = 1'b0;
    #1;
    check("post-reset fetch", {16'd0, instr_rd, instr_addr}, {16'd0, 1'b1, 15'd0});
    check("post-reset A/D", {dbg_a, dbg_d}, 32'd0);

    check("writes drained", expWr.size(), 32'd0);
    check("reads drained", expRd.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
